// File: rtl/button_pkg.sv
// Shared constants and helpers for the push-button front end.
package button_pkg;

  localparam int unsigned BTN_IDX_LEFT            = 0;
  localparam int unsigned BTN_IDX_CENTRE          = 1;
  localparam int unsigned BTN_IDX_RIGHT           = 2;
  localparam int unsigned NUM_BTNS                = 3;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

  typedef logic [NUM_BTNS-1:0] btn_vec_t;

  // A rise survives only if it is the sole rise this edge and no other button was already down.
  function automatic btn_vec_t chord_filter(input btn_vec_t rise, input btn_vec_t level_prev);
    btn_vec_t busy;
    btn_vec_t others;
    btn_vec_t keep;
    busy = rise | level_prev;
    keep = '0;
    for (int b = 0; b < int'(NUM_BTNS); b++) begin
      others    = busy;
      others[b] = 1'b0;
      keep[b]   = rise[b] & ~(|others);
    end
    return keep;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// One button: 2-flop synchroniser, stability counter and debounced level register.
module button_debouncer
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int unsigned CntW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;

  // Next state: count while the synchronised input disagrees with level; any agreement clears.
  always_comb begin
    sync1_d = raw_i;
    sync2_d = sync1_q;
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CntLast) begin
        level_d = ~level_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;
  // Combinational so the top can register the pulse on the same edge level rises.
  assign rise_o  = level_d & ~level_q;

endmodule

// File: rtl/button_pulse_conditioner.sv
// Debounces the three maze buttons and emits chord-filtered one-cycle press pulses.
module button_pulse_conditioner
  import button_pkg::*;
#(
  // Must be >= 2.
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       BTN_LEFT_RAW,
  input  logic       BTN_CENTRE_RAW,
  input  logic       BTN_RIGHT_RAW,
  output logic       BTN_LEFT,
  output logic       BTN_CENTRE,
  output logic       BTN_RIGHT,
  output logic [2:0] BTN_LEVEL
);

  btn_vec_t raw_vec;
  btn_vec_t level_vec;
  btn_vec_t rise_vec;
  btn_vec_t pulse_q, pulse_d;

  assign raw_vec[BTN_IDX_LEFT]   = BTN_LEFT_RAW;
  assign raw_vec[BTN_IDX_CENTRE] = BTN_CENTRE_RAW;
  assign raw_vec[BTN_IDX_RIGHT]  = BTN_RIGHT_RAW;

  for (genvar b = 0; b < int'(NUM_BTNS); b++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clk_i  (CLK),
      .rst_i  (RESET),
      .raw_i  (raw_vec[b]),
      .level_o(level_vec[b]),
      .rise_o (rise_vec[b])
    );
  end

  // Chord rejection uses levels before this edge, so a held button blocks the others.
  always_comb begin
    pulse_d = chord_filter(rise_vec, level_vec);
  end

  // Registered pulse outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pulse_q <= '0;
    end else begin
      pulse_q <= pulse_d;
    end
  end

  assign BTN_LEFT   = pulse_q[BTN_IDX_LEFT];
  assign BTN_CENTRE = pulse_q[BTN_IDX_CENTRE];
  assign BTN_RIGHT  = pulse_q[BTN_IDX_RIGHT];
  assign BTN_LEVEL  = level_vec;

endmodule

// File: tb/tb_button_pulse_conditioner.sv
// Directed bench for button_pulse_conditioner with a cycle-level reference model.
module tb_button_pulse_conditioner;

  localparam int unsigned DC = 4;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       raw_l = 1'b0;
  logic       raw_c = 1'b0;
  logic       raw_r = 1'b0;
  logic       BTN_LEFT, BTN_CENTRE, BTN_RIGHT;
  logic [2:0] BTN_LEVEL;

  button_pulse_conditioner #(
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .BTN_LEFT_RAW  (raw_l),
    .BTN_CENTRE_RAW(raw_c),
    .BTN_RIGHT_RAW (raw_r),
    .BTN_LEFT      (BTN_LEFT),
    .BTN_CENTRE    (BTN_CENTRE),
    .BTN_RIGHT     (BTN_RIGHT),
    .BTN_LEVEL     (BTN_LEVEL)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int errors  = 0;
  int edge_n  = 0;

  // Reference model: level flips once the synchronised input has disagreed for DC edges in a row.
  logic [2:0] m_s1 = '0;
  logic [2:0] m_s2 = '0;
  logic [2:0] m_lvl = '0;
  logic [2:0] m_pulse = '0;
  int         m_run[3];

  always @(posedge CLK) begin : model
    logic [2:0] raw, nl, rise, others;
    edge_n++;
    raw = {raw_r, raw_c, raw_l};
    if (RESET) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pulse = '0;
      for (int b = 0; b < 3; b++) m_run[b] = 0;
    end else begin
      nl = m_lvl;
      for (int b = 0; b < 3; b++) begin
        if (m_s2[b] != m_lvl[b]) begin
          m_run[b] = m_run[b] + 1;
          if (m_run[b] == int'(DC)) begin
            nl[b] = ~nl[b];
            m_run[b] = 0;
          end
        end else begin
          m_run[b] = 0;
        end
      end
      rise = nl & ~m_lvl;
      for (int b = 0; b < 3; b++) begin
        others = m_lvl;
        others[b] = 1'b0;
        m_pulse[b] = rise[b] && ($countones(rise) == 1) && (others == 3'b000);
      end
      m_lvl = nl;
      m_s2  = m_s1;
      m_s1  = raw;
    end
  end

  // Per-cycle compare against the model, plus pulse bookkeeping for the literal checks.
  int         pcnt[3];
  int         plast[3];
  int         lvl_first[3];
  logic [2:0] lvl_prev = '0;

  always @(negedge CLK) begin : compare
    logic [2:0] p;
    p = {BTN_RIGHT, BTN_CENTRE, BTN_LEFT};
    if (edge_n > 0) begin
      vectors++;
      if (p !== m_pulse || BTN_LEVEL !== m_lvl) begin
        errors++;
        $display("FAIL model edge %0d: pulses=%b level=%b, expected pulses=%b level=%b",
                 edge_n, p, BTN_LEVEL, m_pulse, m_lvl);
      end
      vectors++;
      if ($countones(p) > 1) begin
        errors++;
        $display("FAIL onehot edge %0d: pulses=%b, expected at most one set", edge_n, p);
      end
    end
    for (int b = 0; b < 3; b++) begin
      if (p[b] === 1'b1) begin
        pcnt[b]++;
        plast[b] = edge_n;
      end
      if (BTN_LEVEL[b] === 1'b1 && lvl_prev[b] !== 1'b1) lvl_first[b] = edge_n;
    end
    lvl_prev = BTN_LEVEL;
  end

  task automatic check(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic clear_log();
    for (int b = 0; b < 3; b++) begin
      pcnt[b]      = 0;
      plast[b]     = -1;
      lvl_first[b] = -1;
    end
  endtask

  int e;

  initial begin
    clear_log();
    // 1. Reset with all raw inputs high; simultaneous level rises must all be suppressed.
    RESET = 1'b1; raw_l = 1'b1; raw_c = 1'b1; raw_r = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("reset_outputs", int'({BTN_RIGHT, BTN_CENTRE, BTN_LEFT, BTN_LEVEL}), 0);
    end
    RESET = 1'b0;
    clear_log();
    tick(5);
    check("post_reset_quiet", pcnt[0] + pcnt[1] + pcnt[2], 0);
    tick(6);
    check("post_reset_chord", pcnt[0] + pcnt[1] + pcnt[2], 0);
    check("post_reset_level", int'(BTN_LEVEL), 7);
    raw_l = 1'b0; raw_c = 1'b0; raw_r = 1'b0;
    tick(12);

    // 2. Clean centre press: pulse and level both on edge E+DC+1.
    clear_log();
    raw_c = 1'b1; e = edge_n + 1;
    tick(20);
    check("clean_count", pcnt[1], 1);
    check("clean_pulse_edge", plast[1], e + 5);
    check("clean_level_edge", lvl_first[1], e + 5);
    raw_c = 1'b0;
    tick(12);

    // 3. Bouncy left press.
    clear_log();
    raw_l = 1'b1; tick(1);
    raw_l = 1'b0; tick(1);
    raw_l = 1'b1; tick(1);
    raw_l = 1'b0; tick(1);
    raw_l = 1'b1; e = edge_n + 1;
    tick(15);
    check("bounce_count", pcnt[0], 1);
    check("bounce_pulse_edge", plast[0], e + 5);
    raw_l = 1'b0;
    tick(12);

    // 4. Short glitch on right.
    clear_log();
    raw_r = 1'b1; tick(3);
    raw_r = 1'b0; tick(12);
    check("glitch_count", pcnt[2], 0);
    check("glitch_level", lvl_first[2], -1);

    // 5. Chord: right pressed while left held, then a clean right press.
    raw_l = 1'b1; tick(10);
    clear_log();
    raw_r = 1'b1; tick(10);
    check("chord_count", pcnt[2], 0);
    check("chord_level", int'(BTN_LEVEL), 5);
    raw_l = 1'b0; tick(10);
    raw_r = 1'b0; tick(10);
    clear_log();
    raw_r = 1'b1; e = edge_n + 1;
    tick(10);
    check("solo_right_count", pcnt[2], 1);
    check("solo_right_edge", plast[2], e + 5);
    raw_r = 1'b0;
    tick(12);

    // 6. Reset pulse while centre held.
    raw_c = 1'b1; tick(10);
    clear_log();
    RESET = 1'b1; e = edge_n + 1;
    tick(1);
    check("midreset_level", int'(BTN_LEVEL), 0);
    RESET = 1'b0;
    tick(12);
    check("midreset_count", pcnt[1], 1);
    check("midreset_edge", plast[1], e + 6);
    raw_c = 1'b0;
    tick(12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
